// File: rtl/i2c_master_rw_pkg.sv
// Shared types for the I2C read/write master.
// FSM state codes and the quarter-period index type.
package i2c_master_rw_pkg;

    typedef logic [2:0] state_t;
    typedef logic [1:0] quarter_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t START = 3'd1;
    localparam state_t BIT   = 3'd2;
    localparam state_t ACK   = 3'd3;
    localparam state_t STOP  = 3'd4;
    localparam state_t DONE  = 3'd5;

    // SCL is high in the middle two quarters of a bit slot
    function automatic logic scl_high(input quarter_t q);
        return (q == 2'd1) || (q == 2'd2);
    endfunction

endpackage

// File: rtl/i2c_master_rw_if.sv
// Request/response and pin bundle between the init FSM and the I2C master.
// The master modport is the DUT side, slave is the requester/pin side.
interface i2c_master_rw_if #(
    parameter int BYTE = 3
);
    localparam int NW = $clog2(BYTE + 1);

    logic              i_start;
    logic              i_rw;
    logic [NW-1:0]     i_nbyte;
    logic [8*BYTE-1:0] i_dat;
    logic              i_sdat;
    logic [8*BYTE-1:0] o_dat;
    logic              o_busy;
    logic              o_finished;
    logic              o_nack;
    logic              o_sclk;
    logic              o_sdat;
    logic              o_sdat_oe;

    modport master (
        input  i_start, i_rw, i_nbyte, i_dat, i_sdat,
        output o_dat, o_busy, o_finished, o_nack,
        output o_sclk, o_sdat, o_sdat_oe
    );

    modport slave (
        output i_start, i_rw, i_nbyte, i_dat, i_sdat,
        input  o_dat, o_busy, o_finished, o_nack,
        input  o_sclk, o_sdat, o_sdat_oe
    );

endinterface

// File: rtl/i2c_master_rw_qtick.sv
// SCL quarter-period timebase: one tick every CLK_DIV cycles while enabled.
// Clearing restarts both the cycle counter and the quarter index.
module i2c_master_rw_qtick
    import i2c_master_rw_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_clear,
    input  logic     i_en,
    output logic     o_tick,
    output quarter_t o_quarter
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign o_tick = i_en && !i_clear && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            cnt       <= '0;
            o_quarter <= '0;
        end else if (o_tick) begin
            cnt       <= '0;
            o_quarter <= o_quarter + 2'd1;
        end else if (i_en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master_rw.sv
// I2C master: START, address byte, up to BYTE-1 write/read bytes, STOP.
// All pin and status outputs are registered from the next-state values.
module i2c_master_rw
    import i2c_master_rw_pkg::*;
#(
    parameter int BYTE      = 3,
    parameter int CLK_DIV   = 4,
    parameter int ACK_CHECK = 1
) (
    input logic             i_clk,
    input logic             i_rst,
    i2c_master_rw_if.master bus
);
    localparam int NW = $clog2(BYTE + 1);
    localparam int DW = 8 * BYTE;

    state_t        state, state_n;
    quarter_t      quarter, quarter_n;
    logic          tick, clear, run;
    logic [2:0]    bit_cnt, bit_n;
    logic [NW-1:0] byte_cnt, byte_n;
    logic [NW-1:0] nbyte, nbyte_n, nbyte_req;
    logic          rw, rw_n;
    logic [DW-1:0] sh, sh_n;
    logic [DW-1:0] dat, dat_n;
    logic [7:0]    rd, rd_n;
    logic          nack, nack_n;
    logic          rd_byte, last;
    logic          rd_byte_n, last_n;
    logic          sclk, sdat, oe, busy, finished;
    logic          sclk_n, sdat_n, oe_n;

    assign clear = (state == IDLE) && bus.i_start;
    assign run   = (state != IDLE) && (state != DONE);

    i2c_master_rw_qtick #(
        .CLK_DIV(CLK_DIV)
    ) u_qtick (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (clear),
        .i_en     (run),
        .o_tick   (tick),
        .o_quarter(quarter)
    );

    always_comb begin
        if (bus.i_nbyte == '0)
            nbyte_req = NW'(1);
        else if ({1'b0, bus.i_nbyte} > (NW + 1)'(BYTE))
            nbyte_req = NW'(BYTE);
        else
            nbyte_req = bus.i_nbyte;
    end

    assign rd_byte   = rw && (byte_cnt != '0);
    assign last      = byte_cnt == nbyte - NW'(1);
    assign rd_byte_n = rw_n && (byte_n != '0);
    assign last_n    = byte_n == nbyte_n - NW'(1);

    always_comb begin
        state_n   = state;
        bit_n     = bit_cnt;
        byte_n    = byte_cnt;
        nbyte_n   = nbyte;
        rw_n      = rw;
        sh_n      = sh;
        rd_n      = rd;
        dat_n     = dat;
        nack_n    = nack;
        quarter_n = clear ? '0 : (tick ? quarter + 2'd1 : quarter);
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_n = START;
                    bit_n   = '0;
                    byte_n  = '0;
                    nbyte_n = nbyte_req;
                    rw_n    = bus.i_rw;
                    sh_n    = bus.i_dat;
                    dat_n   = '0;
                    nack_n  = 1'b0;
                end
            end
            START: begin
                if (tick && quarter == 2'd3)
                    state_n = BIT;
            end
            BIT: begin
                if (tick) begin
                    if (quarter == 2'd2 && rd_byte) begin
                        rd_n = {rd[6:0], bus.i_sdat};
                        if (bit_cnt == 3'd7) begin
                            for (int k = 1; k < BYTE; k++)
                                if (byte_cnt == NW'(k))
                                    dat_n[DW-8*k-1 -: 8] = rd_n;
                        end
                    end
                    if (quarter == 2'd3) begin
                        sh_n = sh << 1;
                        if (bit_cnt == 3'd7)
                            state_n = ACK;
                        else
                            bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            ACK: begin
                if (tick) begin
                    if (quarter == 2'd2 && !rd_byte && bus.i_sdat)
                        nack_n = 1'b1;
                    if (quarter == 2'd3) begin
                        if (ACK_CHECK != 0 && !rd_byte && nack) begin
                            state_n = STOP;
                        end else if (last) begin
                            state_n = STOP;
                        end else begin
                            state_n = BIT;
                            bit_n   = '0;
                            byte_n  = byte_cnt + NW'(1);
                        end
                    end
                end
            end
            STOP: begin
                if (tick && quarter == 2'd3)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pin levels for the quarter about to start
    always_comb begin
        sclk_n = 1'b1;
        sdat_n = 1'b1;
        oe_n   = 1'b0;
        case (state_n)
            START: begin
                sclk_n = quarter_n != 2'd3;
                sdat_n = quarter_n == 2'd0;
                oe_n   = 1'b1;
            end
            BIT: begin
                sclk_n = scl_high(quarter_n);
                if (!rd_byte_n) begin
                    oe_n   = 1'b1;
                    sdat_n = sh_n[DW-1];
                end
            end
            ACK: begin
                sclk_n = scl_high(quarter_n);
                if (rd_byte_n && !last_n) begin
                    oe_n   = 1'b1;
                    sdat_n = 1'b0;
                end
            end
            STOP: begin
                sclk_n = quarter_n != 2'd0;
                sdat_n = quarter_n[1];
                oe_n   = quarter_n != 2'd3;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            nbyte    <= NW'(1);
            rw       <= 1'b0;
            sh       <= '0;
            rd       <= '0;
            dat      <= '0;
            nack     <= 1'b0;
            sclk     <= 1'b1;
            sdat     <= 1'b1;
            oe       <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_n;
            byte_cnt <= byte_n;
            nbyte    <= nbyte_n;
            rw       <= rw_n;
            sh       <= sh_n;
            rd       <= rd_n;
            dat      <= dat_n;
            nack     <= nack_n;
            sclk     <= sclk_n;
            sdat     <= sdat_n;
            oe       <= oe_n;
            busy     <= state_n != IDLE;
            finished <= state_n == DONE;
        end
    end

    assign bus.o_dat      = dat;
    assign bus.o_busy     = busy;
    assign bus.o_finished = finished;
    assign bus.o_nack     = nack;
    assign bus.o_sclk     = sclk;
    assign bus.o_sdat     = sdat;
    assign bus.o_sdat_oe  = oe;

endmodule

// File: tb/tb_i2c_master_rw.sv
// Directed bench for i2c_master_rw with a bit-level open-drain slave model.
// A second instance with ACK_CHECK=0 runs alongside for the no-abort case.
module tb_i2c_master_rw;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_master_rw_if #(.BYTE(3)) bus ();
    i2c_master_rw_if #(.BYTE(3)) bus2 ();

    i2c_master_rw #(
        .BYTE(3), .CLK_DIV(4), .ACK_CHECK(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );

    i2c_master_rw #(
        .BYTE(3), .CLK_DIV(4), .ACK_CHECK(0)
    ) dut2 (
        .i_clk(clk), .i_rst(rst), .bus(bus2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // slave model configuration
    int         tn = 3;
    bit         trw = 1'b0;
    bit         nack_addr = 1'b0;
    logic [7:0] rdb [3];

    // slave model / bus monitor state
    logic cap [64];
    int   falls = 0, rises = 0, rises2 = 0;
    int   s, b, j;
    logic sl, line = 1'b1;
    logic pscl = 1'b1, pline = 1'b1, pscl2 = 1'b1;
    bit   start_seen = 1'b0, stop_seen = 1'b0;

    always @(posedge clk) begin
        #1;
        if (!bus.o_busy) begin
            falls = 0;
            rises = 0;
            start_seen = 1'b0;
            stop_seen = 1'b0;
        end else if (pscl && !bus.o_sclk) begin
            falls++;
        end
        sl = 1'b1;
        if (falls >= 1) begin
            s = falls - 1;
            b = s / 9;
            j = s % 9;
            if (b < tn) begin
                if (j == 8)
                    sl = (b == 0 && nack_addr) || (trw && b > 0);
                else if (trw && b > 0)
                    sl = rdb[b][7-j];
            end
        end
        line = (bus.o_sdat_oe ? bus.o_sdat : 1'b1) & sl;
        bus.i_sdat = line;
        if (bus.o_busy) begin
            if (!pscl && bus.o_sclk) begin
                if (rises < 64) cap[rises] = line;
                rises++;
            end
            if (pscl && bus.o_sclk && pline && !line) start_seen = 1'b1;
            if (pscl && bus.o_sclk && !pline && line) stop_seen = 1'b1;
        end
        pscl = bus.o_sclk;
        pline = line;
    end

    always @(posedge clk) begin
        #1;
        if (!bus2.o_busy) rises2 = 0;
        else if (!pscl2 && bus2.o_sclk) rises2++;
        pscl2 = bus2.o_sclk;
    end

    function automatic logic [7:0] cap_byte(input int bi);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v = {v[6:0], cap[9*bi+k]};
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic run(input bit rw, input logic [1:0] nb,
                       input logic [23:0] d, output int cyc);
        bus.i_rw = rw;
        bus.i_nbyte = nb;
        bus.i_dat = d;
        bus.i_start = 1'b1;
        cyc = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_dat = ~d;
        bus.i_rw = ~rw;
        bus.i_nbyte = 2'd1;
        while (!bus.o_finished && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        if (!bus.o_finished) check("timeout", bus.o_finished, 1);
    endtask

    localparam logic [23:0] WDAT = 24'h341E00;

    int cyc, c, c1, c2, r1, r2;
    bit st1, n1, n2, a1;

    initial begin
        bus.i_start = 1'b0;
        bus.i_rw = 1'b0;
        bus.i_nbyte = 2'd3;
        bus.i_dat = '0;
        bus2.i_start = 1'b0;
        bus2.i_rw = 1'b0;
        bus2.i_nbyte = 2'd3;
        bus2.i_dat = '0;
        bus2.i_sdat = 1'b1;
        rdb[0] = 8'h00;
        rdb[1] = 8'hA5;
        rdb[2] = 8'h5A;

        @(negedge clk);
        step(3);
        check("rst_pins", {bus.o_sclk, bus.o_sdat, bus.o_sdat_oe,
                           bus.o_busy, bus.o_finished, bus.o_nack}, 6'b110000);
        check("rst_dat", bus.o_dat, 0);
        rst = 1'b0;
        step(2);

        // plain 3-byte write, slave ACKs everything
        tn = 3; trw = 1'b0; nack_addr = 1'b0;
        run(1'b0, 2'd3, WDAT, cyc);
        check("wr_cyc", cyc, 465);
        check("wr_nack", bus.o_nack, 0);
        check("wr_start", start_seen, 1);
        check("wr_stop", stop_seen, 1);
        check("wr_rises", rises, 28);
        check("wr_b0", cap_byte(0), 8'h34);
        check("wr_b1", cap_byte(1), 8'h1E);
        check("wr_b2", cap_byte(2), 8'h00);
        check("wr_acks", {cap[8], cap[17], cap[26]}, 3'b000);
        check("wr_busy_fin", bus.o_busy, 1);

        // start during DONE is ignored, accepted one cycle later
        bus.i_start = 1'b1;
        bus.i_dat = WDAT;
        bus.i_rw = 1'b0;
        bus.i_nbyte = 2'd3;
        step(1);
        check("done_ign", bus.o_busy, 0);
        check("idle_bus", {bus.o_sclk, bus.o_sdat_oe, bus.o_finished}, 3'b100);
        run(1'b0, 2'd3, WDAT, cyc);
        check("b2b_cyc", cyc, 465);
        check("b2b_bytes", {cap_byte(0), cap_byte(1), cap_byte(2)}, WDAT);
        check("b2b_nack", bus.o_nack, 0);
        step(2);

        // address NACK: dut aborts, dut2 (no ack check) sends everything
        nack_addr = 1'b1;
        bus.i_rw = 1'b0; bus.i_nbyte = 2'd3; bus.i_dat = WDAT;
        bus2.i_rw = 1'b0; bus2.i_nbyte = 2'd3; bus2.i_dat = WDAT;
        bus.i_start = 1'b1;
        bus2.i_start = 1'b1;
        c = 0; c1 = 0; c2 = 0; r1 = 0; r2 = 0;
        st1 = 1'b0; n1 = 1'b0; n2 = 1'b0; a1 = 1'b0;
        @(posedge clk);
        c++;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus2.i_start = 1'b0;
        while ((c1 == 0 || c2 == 0) && c < 2000) begin
            if (c1 == 0 && bus.o_finished) begin
                c1 = c; r1 = rises; st1 = stop_seen;
                n1 = bus.o_nack; a1 = cap[8];
            end
            if (c2 == 0 && bus2.o_finished) begin
                c2 = c; r2 = rises2; n2 = bus2.o_nack;
            end
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        check("nk_cyc", c1, 177);
        check("nk_nack", n1, 1);
        check("nk_rises", r1, 10);
        check("nk_stop", st1, 1);
        check("nk_ackbit", a1, 1);
        check("nk_hold", bus.o_nack, 1);
        check("nc_cyc", c2, 465);
        check("nc_nack", n2, 1);
        check("nc_rises", r2, 28);
        nack_addr = 1'b0;
        step(2);

        // read two bytes after address 0x35
        tn = 3; trw = 1'b1;
        run(1'b1, 2'd3, 24'h350000, cyc);
        check("rd_cyc", cyc, 465);
        check("rd_dat", bus.o_dat, 24'h00A55A);
        check("rd_addr", cap_byte(0), 8'h35);
        check("rd_acks", {cap[8], cap[17], cap[26]}, 3'b001);
        check("rd_nack", bus.o_nack, 0);
        trw = 1'b0;
        step(2);

        // start pulse mid-transfer ignored, then reset mid-byte
        bus.i_rw = 1'b0; bus.i_nbyte = 2'd3; bus.i_dat = WDAT;
        bus.i_start = 1'b1;
        step(1);
        bus.i_start = 1'b0;
        step(29);
        bus.i_start = 1'b1;
        bus.i_dat = 24'hAA0000;
        bus.i_nbyte = 2'd1;
        step(1);
        bus.i_start = 1'b0;
        step(69);
        check("mid_busy", bus.o_busy, 1);
        check("mid_rises", rises, 5);
        check("mid_bits", {cap[0], cap[1], cap[2], cap[3], cap[4]}, 5'b00110);
        rst = 1'b1;
        step(1);
        check("mid_rst", {bus.o_sclk, bus.o_sdat, bus.o_sdat_oe,
                          bus.o_busy, bus.o_finished, bus.o_nack}, 6'b110000);
        rst = 1'b0;
        step(2);
        run(1'b0, 2'd3, WDAT, cyc);
        check("post_cyc", cyc, 465);
        check("post_bytes", {cap_byte(0), cap_byte(1), cap_byte(2)}, WDAT);
        check("post_stop", stop_seen, 1);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
